// File: rtl/kbd_tx_wb_pkg.sv
// Shared definitions for the keyboard TX Wishbone block: register addresses
// and status word layout, common with the RX side.
package kbd_tx_wb_pkg;

    typedef enum logic [1:0] {
        KBD_TX_DATA = 2'd0,
        KBD_TX_STAT = 2'd1,
        KBD_RSVD_2  = 2'd2,
        KBD_RSVD_3  = 2'd3
    } kbd_addr_e;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_BUSY    = 3;
    localparam int STAT_TXEN    = 4;
    localparam int STAT_LVL_LSB = 8;

    function automatic logic [15:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic       busy,
        input logic       txen,
        input logic [7:0] level
    );
        logic [15:0] s;
        s                           = '0;
        s[STAT_EMPTY]               = empty;
        s[STAT_FULL]                = full;
        s[STAT_OVF]                 = ovf;
        s[STAT_BUSY]                = busy;
        s[STAT_TXEN]                = txen;
        s[STAT_LVL_LSB +: 8]        = level;
        return s;
    endfunction

endpackage

// File: rtl/kbd_tx_wb_fifo_sync_ram.sv
// fifo_sync_ram: single-clock byte FIFO. Writes become readable one cycle
// after the write edge, as with a registered RAM read port.
module fifo_sync_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_vis_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            wr_vis_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            // read side sees the write pointer one cycle late
            wr_vis_q <= wr_ptr_q;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_valid_o = (wr_vis_q != rd_ptr_q);
    assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/kbd_tx_wb.sv
// Wishbone-slave byte transmitter: CPU pushes bytes into a TX FIFO which is
// drained through a one-register valid/ready output stage toward the BLE link.
module kbd_tx_wb
    import kbd_tx_wb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    wb_addr,
    output logic [DW-1:0] wb_rdata,
    input  logic [DW-1:0] wb_wdata,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic          wb_ack,
    output logic [7:0]    kbd_tx_data,
    output logic          kbd_tx_valid,
    input  logic          kbd_tx_ready
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic          ack_q,   ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q,   ovf_d;
    logic          txen_q,  txen_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q,  data_d;

    kbd_addr_e     addr;
    logic          req;
    logic          wr_data;
    logic          wr_stat;
    logic          rd_stat;
    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;
    logic          pop;
    logic          head_valid;
    logic [7:0]    head_data;
    logic [15:0]   status;

    fifo_sync_ram #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (~rst_n),
        .wr_en_i    (accept),
        .wr_data_i  (wb_wdata[7:0]),
        .rd_en_i    (pop),
        .rd_data_o  (head_data),
        .rd_valid_o (head_valid)
    );

    assign addr       = kbd_addr_e'(wb_addr);
    assign req        = wb_cyc & ~ack_q;
    assign wr_data    = req & wb_we & (addr == KBD_TX_DATA);
    assign wr_stat    = req & wb_we & (addr == KBD_TX_STAT);
    assign rd_stat    = req & ~wb_we & (addr == KBD_TX_STAT);
    assign fifo_empty = (level_q == '0);
    // full is judged before this edge's pop, so a push at DEPTH always drops
    assign fifo_full  = (level_q == LW'(DEPTH));
    assign accept     = wr_data & ~fifo_full;
    assign pop        = (~valid_q | kbd_tx_ready) & head_valid & txen_q;

    assign status = pack_status(fifo_empty, fifo_full, ovf_q, valid_q, txen_q, 8'(level_q));

    always_comb begin
        ack_d   = req;
        rdata_d = rd_stat ? DW'(status) : '0;
        level_d = level_q + LW'(accept) - LW'(pop);

        ovf_d = ovf_q;
        if (wr_stat && wb_wdata[STAT_OVF]) ovf_d = 1'b0;
        if (wr_data && fifo_full)          ovf_d = 1'b1;

        txen_d = wr_stat ? wb_wdata[STAT_TXEN] : txen_q;

        valid_d = valid_q;
        data_d  = data_q;
        if (pop) begin
            valid_d = 1'b1;
            data_d  = head_data;
        end else if (kbd_tx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            txen_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            txen_q  <= txen_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign wb_ack       = ack_q;
    assign wb_rdata     = rdata_q;
    assign kbd_tx_valid = valid_q;
    assign kbd_tx_data  = data_q;

endmodule
